// File: rtl/buffer_route_sequencer_pkg.sv
// rtl/buffer_route_sequencer_pkg.sv - shared types and helpers for the buffer route sequencer
package buffer_route_sequencer_pkg;

    localparam int ROUTE_SEL_W  = 5;
    localparam int ROUTE_BEAT_W = 16;
    localparam int ROUTE_REV_W  = 8;

    typedef enum logic [1:0] {
        MODE_IDENT  = 2'd0,
        MODE_ROT    = 2'd1,
        MODE_INC    = 2'd2,
        MODE_BITREV = 2'd3
    } route_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } route_state_e;

    typedef struct packed {
        route_mode_e               mode;
        logic [ROUTE_SEL_W-1:0]    shift;
        logic [ROUTE_BEAT_W-1:0]   beats;
    } route_cmd_t;

    // Reverse the low w bits of v (w <= ROUTE_REV_W).
    function automatic logic [ROUTE_REV_W-1:0] bitrev(input logic [ROUTE_REV_W-1:0] v, input int w);
        logic [ROUTE_REV_W-1:0] full;
        full = {<<{v}};
        return full >> (ROUTE_REV_W - w);
    endfunction

endpackage

// File: rtl/buffer_route_sequencer_delay_line.sv
// rtl/buffer_route_sequencer_delay_line.sv - route_delay_line: DEPTH-deep {valid,last} tag pipe, reset-cleared
module route_delay_line #(
    parameter int DEPTH = 5
) (
    input  logic clk,
    input  logic rstn,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last
);

    logic [DEPTH-1:0] valid_sr;
    logic [DEPTH-1:0] last_sr;

    if (DEPTH > 1) begin : g_deep
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                valid_sr <= '0;
                last_sr  <= '0;
            end else begin
                valid_sr <= {valid_sr[DEPTH-2:0], in_valid};
                last_sr  <= {last_sr[DEPTH-2:0], in_last};
            end
        end
    end else begin : g_one
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                valid_sr <= '0;
                last_sr  <= '0;
            end else begin
                valid_sr <= in_valid;
                last_sr  <= in_last;
            end
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_last  = last_sr[DEPTH-1];

endmodule

// File: rtl/buffer_route_sequencer.sv
// rtl/buffer_route_sequencer.sv - routing command sequencer issuing per-slot selects with matched valid/last delay.
// ROUTE_CMD_SKID_EN adds a one-entry pending command register for back-to-back commands.
module buffer_route_sequencer
    import buffer_route_sequencer_pkg::*;
#(
    parameter int  MODULE_SLOTS = 32,
    parameter int  NTT_SLOTS    = 32,
    parameter int  STAGE_MODULE = 5,
    parameter int  LATENCY      = STAGE_MODULE,
    parameter int  BEAT_W       = ROUTE_BEAT_W,
    localparam int SEL_W        = $clog2(NTT_SLOTS)
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [1:0]                            cmd_mode,
    input  logic [SEL_W-1:0]                      cmd_shift,
    input  logic [BEAT_W-1:0]                     cmd_beats,
    input  logic                                  stall,
    output logic [MODULE_SLOTS-1:0][SEL_W-1:0]    module_slots,
    output logic [MODULE_SLOTS-1:0][SEL_W-1:0]    ram_slots,
    output logic                                  issue_valid,
    output logic                                  data_valid,
    output logic                                  cmd_done,
    output logic                                  busy
);

    localparam int OUT_W = $clog2(LATENCY + 3);

    route_state_e                         state_q, state_d;
    route_mode_e                          mode_q, mode_d, src_mode;
    logic [SEL_W-1:0]                     shift_q, shift_d, src_shift;
    logic [SEL_W-1:0]                     beat_q, beat_d, src_beat, rot;
    logic [BEAT_W-1:0]                    remain_q, remain_d, src_remain, remain_after;
    logic                                 src_live, idle_accept, do_issue, tag_last;
    logic                                 issue_last_q, zero_done_q, load_pending;
    logic [OUT_W-1:0]                     inflight_q;
    logic                                 dl_valid, dl_last;
    logic                                 pending_valid_q;
    route_cmd_t                           pending_q;
    logic [MODULE_SLOTS-1:0][SEL_W-1:0]   ram_d, mod_d;

`ifdef ROUTE_CMD_SKID_EN
    localparam bit SKID_EN = 1'b1;

    assign cmd_ready = !pending_valid_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_valid_q <= 1'b0;
            pending_q       <= '0;
        end else if (load_pending) begin
            pending_valid_q <= 1'b0;
        end else if (cmd_valid && cmd_ready && state_q != ST_IDLE) begin
            pending_valid_q <= 1'b1;
            pending_q       <= '{mode: route_mode_e'(cmd_mode), shift: cmd_shift, beats: cmd_beats};
        end
    end
`else
    localparam bit SKID_EN = 1'b0;

    assign cmd_ready       = (state_q == ST_IDLE);
    assign pending_valid_q = 1'b0;
    assign pending_q       = '0;
`endif

    // The beat source is the incoming command on an IDLE accept, so the first beat leaves on the accept edge.
    always_comb begin
        idle_accept = (state_q == ST_IDLE) && cmd_valid && cmd_ready;
        src_mode    = mode_q;
        src_shift   = shift_q;
        src_beat    = beat_q;
        src_remain  = remain_q;
        src_live    = (state_q == ST_RUN);
        if (idle_accept) begin
            src_mode   = route_mode_e'(cmd_mode);
            src_shift  = cmd_shift;
            src_beat   = '0;
            src_remain = cmd_beats;
            src_live   = 1'b1;
        end
        do_issue     = src_live && !stall && (src_remain != '0);
        remain_after = src_remain - BEAT_W'(do_issue);
        tag_last     = src_live && (remain_after == '0) && (do_issue || state_q == ST_RUN);
        case (src_mode)
            MODE_ROT: rot = src_shift;
            MODE_INC: rot = src_shift + src_beat;
            default:  rot = '0;
        endcase
    end

    for (genvar g = 0; g < MODULE_SLOTS; g++) begin : g_slot
        localparam logic [SEL_W-1:0]       IDX = SEL_W'(g);
        localparam logic [ROUTE_REV_W-1:0] REV = bitrev(ROUTE_REV_W'(g), SEL_W);
        assign ram_d[g] = (src_mode == MODE_BITREV) ? REV[SEL_W-1:0] : IDX + rot;
        assign mod_d[g] = (src_mode == MODE_BITREV) ? REV[SEL_W-1:0] : IDX - rot;
    end

    // DRAIN waits for the final in-flight last tag; earlier commands may still have tags in the pipe.
    always_comb begin
        state_d      = state_q;
        mode_d       = src_mode;
        shift_d      = src_shift;
        beat_d       = src_beat + SEL_W'(do_issue);
        remain_d     = remain_after;
        load_pending = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (idle_accept && cmd_beats != '0)
                    state_d = (remain_after == '0) ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                if (remain_after == '0) begin
                    if (SKID_EN && pending_valid_q) load_pending = 1'b1;
                    else                            state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dl_last && inflight_q == OUT_W'(1)) begin
                    if (SKID_EN && pending_valid_q) load_pending = 1'b1;
                    else                            state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load_pending) begin
            mode_d   = pending_q.mode;
            shift_d  = pending_q.shift;
            beat_d   = '0;
            remain_d = pending_q.beats;
            state_d  = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_IDENT;
            shift_q      <= '0;
            beat_q       <= '0;
            remain_q     <= '0;
            issue_valid  <= 1'b0;
            issue_last_q <= 1'b0;
            zero_done_q  <= 1'b0;
            inflight_q   <= '0;
            module_slots <= '0;
            ram_slots    <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            shift_q      <= shift_d;
            beat_q       <= beat_d;
            remain_q     <= remain_d;
            issue_valid  <= do_issue;
            issue_last_q <= tag_last;
            zero_done_q  <= idle_accept && (cmd_beats == '0);
            inflight_q   <= inflight_q + OUT_W'(tag_last) - OUT_W'(dl_last);
            if (do_issue) begin
                module_slots <= mod_d;
                ram_slots    <= ram_d;
            end
        end
    end

    route_delay_line #(
        .DEPTH (LATENCY)
    ) u_delay (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (issue_valid),
        .in_last   (issue_last_q),
        .out_valid (dl_valid),
        .out_last  (dl_last)
    );

    assign data_valid = dl_valid;
    assign cmd_done   = dl_last | zero_done_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_buffer_route_sequencer.sv
// tb/tb_buffer_route_sequencer.sv - scoreboard bench for buffer_route_sequencer
module tb_buffer_route_sequencer;

    localparam int NS  = 32;
    localparam int SW  = 5;
    localparam int BW  = 16;
    localparam int LAT = 5;

    typedef logic [NS-1:0][SW-1:0] sel_vec_t;
    typedef struct {
        int       cyc;
        sel_vec_t ram;
        sel_vec_t mdl;
    } beat_t;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [1:0]     cmd_mode = '0;
    logic [SW-1:0]  cmd_shift = '0;
    logic [BW-1:0]  cmd_beats = '0;
    logic           stall = 1'b0;
    sel_vec_t       module_slots, ram_slots;
    logic           issue_valid, data_valid, cmd_done, busy;

    buffer_route_sequencer dut (
        .clk          (clk),
        .rstn         (rstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_mode     (cmd_mode),
        .cmd_shift    (cmd_shift),
        .cmd_beats    (cmd_beats),
        .stall        (stall),
        .module_slots (module_slots),
        .ram_slots    (ram_slots),
        .issue_valid  (issue_valid),
        .data_valid   (data_valid),
        .cmd_done     (cmd_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    beat_t    iss_q[$];
    int       dv_q[$];
    int       done_q[$];
    sel_vec_t last_ram = '0;
    int       n_checks = 0;
    int       n_pass = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    function automatic int bitrev5(input int v);
        int r = 0;
        for (int k = 0; k < SW; k++)
            if (((v >> k) & 1) != 0) r = r | (1 << (SW - 1 - k));
        return r;
    endfunction

    // Selects for beat b of a command, straight from the permutation definitions.
    function automatic beat_t make_beat(input int t, input int mode, input int shift, input int b);
        beat_t be;
        int    r;
        be.cyc = t;
        r = (mode == 1) ? shift : (mode == 2) ? (shift + b) % NS : 0;
        for (int i = 0; i < NS; i++) begin
            if (mode == 3) begin
                be.ram[i] = SW'(bitrev5(i));
                be.mdl[i] = SW'(bitrev5(i));
            end else begin
                be.ram[i] = SW'((i + r) % NS);
                be.mdl[i] = SW'(((i - r) % NS + NS) % NS);
            end
        end
        return be;
    endfunction

    beat_t mb;
    bit    exp_i, exp_d, exp_c;

    always @(negedge clk) begin
        if (rstn) begin
            exp_i = (iss_q.size() > 0) && (iss_q[0].cyc == cyc);
            exp_d = (dv_q.size() > 0) && (dv_q[0] == cyc);
            exp_c = (done_q.size() > 0) && (done_q[0] == cyc);
            if (issue_valid || exp_i) begin
                check("issue_valid", issue_valid, exp_i);
                if (exp_i) begin
                    mb = iss_q.pop_front();
                    if (issue_valid) begin
                        check("ram_slots", ram_slots, mb.ram);
                        check("module_slots", module_slots, mb.mdl);
                    end
                    last_ram = mb.ram;
                end
            end else begin
                check("sel_hold", ram_slots, last_ram);
            end
            if (data_valid || exp_d) begin
                check("data_valid", data_valid, exp_d);
                if (exp_d) void'(dv_q.pop_front());
            end
            if (cmd_done || exp_c) begin
                check("cmd_done", cmd_done, exp_c);
                if (exp_c) void'(done_q.pop_front());
            end
        end
    end

    // stall_kind: 0 none, 1 random, 2 stall on the cycles that would issue beats 2 and 3.
    task automatic run_cmd(input int mode, input int shift, input int beats, input int stall_kind);
        bit st[64];
        int c, t, b, last_t, waited;
        for (int k = 0; k < 64; k++) begin
            case (stall_kind)
                1:       st[k] = ($urandom_range(0, 3) == 0);
                2:       st[k] = (k == 2 || k == 3);
                default: st[k] = 1'b0;
            endcase
            if (k >= 40 && k < 44) st[k] = 1'b0;
            if (k >= 44 && stall_kind != 1) st[k] = 1'b0;
        end
        for (int k = 0; k < 40 + beats && k < 64; k++)
            if (k >= 40) st[k] = 1'b0;
        waited = 0;
        while (!cmd_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check("cmd_ready_before_cmd", cmd_ready, 1'b1);
        c = cyc;
        cmd_valid = 1'b1;
        cmd_mode  = 2'(mode);
        cmd_shift = SW'(shift);
        cmd_beats = BW'(beats);
        stall     = st[0];
        b = 0;
        t = c;
        last_t = c;
        while (b < beats) begin
            if (!st[t - c]) begin
                iss_q.push_back(make_beat(t + 1, mode, shift, b));
                dv_q.push_back(t + 1 + LAT);
                if (b == beats - 1) begin
                    done_q.push_back(t + 1 + LAT);
                    last_t = t + 1 + LAT;
                end
                b++;
            end
            t++;
        end
        if (beats == 0) done_q.push_back(c + 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_mode  = 2'($urandom);
        cmd_shift = SW'($urandom);
        cmd_beats = BW'($urandom);
        while (cyc < last_t) begin
            stall = (cyc - c < 64) ? st[cyc - c] : 1'b0;
            @(posedge clk); #1;
        end
        if (beats > 0) begin
            check("busy_at_done", busy, 1'b1);
            check("cmd_ready_at_done", cmd_ready, 1'b0);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        check("cmd_ready_after_done", cmd_ready, 1'b1);
        check("busy_after_done", busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_issue_valid"}, issue_valid, 1'b0);
        check({tag, "_data_valid"}, data_valid, 1'b0);
        check({tag, "_cmd_done"}, cmd_done, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        check({tag, "_ram_slots"}, ram_slots, '0);
        check({tag, "_module_slots"}, module_slots, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int c, dones;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        run_cmd(0, 0, 3, 0);
        run_cmd(1, 5, 4, 0);
        run_cmd(2, 30, 4, 0);
        run_cmd(3, 0, 1, 0);
        run_cmd(2, 7, 6, 2);
        run_cmd(1, 3, 0, 0);

        for (int n = 0; n < 25; n++) begin
            run_cmd($urandom_range(0, 3), $urandom_range(0, NS - 1),
                    ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 20),
                    $urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Abort a 10-beat command with reset right after its second beat issues.
        check("cmd_ready_before_abort", cmd_ready, 1'b1);
        c = cyc;
        cmd_valid = 1'b1;
        cmd_mode  = 2'd2;
        cmd_shift = 5'd9;
        cmd_beats = 16'd10;
        iss_q.push_back(make_beat(c + 1, 2, 9, 0));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        iss_q.delete();
        dv_q.delete();
        done_q.delete();
        last_ram = '0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (cmd_done) dones++;
        end
        check("no_done_after_abort", dones, 0);

        run_cmd(0, 0, 2, 0);
        repeat (3) @(posedge clk);
        #1;
        check("queues_drained", iss_q.size() + dv_q.size() + done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
